// File: rtl/pcxt_clk_en_gen.sv
`default_nettype none
// ============================================================================
// Module   : pcxt_clk_en_gen
// Purpose  : PC/XT clock-enable generator. Waits for a stable PLL lock,
//            releases the core reset and then produces the CPU and PIT clock
//            enables derived from the 14.318 MHz master clock.
// Ports    : clk        - 14.318 MHz PLL output, rising-edge logic
//            rst_n      - synchronous active-low reset
//            pll_locked - PLL lock indicator (asynchronous to clk)
//            turbo      - 1 selects CPU_DIV_TURBO, 0 selects CPU_DIV_NORM
//            core_rst_n - active-low reset to CPU/peripherals
//            cpu_ce     - single-cycle CPU clock enable
//            cpu_clk    - 8284-style CPU phase clock
//            pit_ce     - single-cycle 8253 PIT clock enable
//            lock_lost  - sticky: lock dropped after RUN was reached
// Revision : 1.0 - initial release
// ============================================================================
module pcxt_clk_en_gen #(
  parameter int LOCK_WAIT     = 1024,
  parameter int CPU_DIV_NORM  = 3,
  parameter int CPU_DIV_TURBO = 2,
  parameter int PIT_DIV       = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_locked,
  input  logic turbo,
  output logic core_rst_n,
  output logic cpu_ce,
  output logic cpu_clk,
  output logic pit_ce,
  output logic lock_lost
);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_STAB = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [15:0] STAB_LAST = 16'(LOCK_WAIT - 1);
  localparam logic [3:0]  DIV_NORM  = 4'(CPU_DIV_NORM);
  localparam logic [3:0]  DIV_TURBO = 4'(CPU_DIV_TURBO);
  localparam logic [7:0]  PIT_LAST  = 8'(PIT_DIV - 1);

  state_t      state;
  logic        sync1;
  logic        locked_s;
  logic [15:0] stab_cnt;
  logic [3:0]  cpu_cnt;
  logic [3:0]  cur_div;
  logic [7:0]  pit_cnt;

  logic        in_run;
  logic        cpu_wrap;
  logic        pit_wrap;
  logic [3:0]  sel_div;
  logic        clk_high;

  assign in_run   = (state == S_RUN);
  assign cpu_wrap = (cpu_cnt == cur_div - 4'd1);
  assign pit_wrap = (pit_cnt == PIT_LAST);
  assign sel_div  = turbo ? DIV_TURBO : DIV_NORM;

  // High phase is floor(div/2) counts; for div=3 that yields the 8284's
  // one-third duty (count 0 only). Div=1 has no low phase at all.
  assign clk_high = (cur_div == 4'd1) ? 1'b1 : (cpu_cnt < (cur_div >> 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1      <= 1'b0;
      locked_s   <= 1'b0;
      state      <= S_WAIT;
      stab_cnt   <= 16'd0;
      cpu_cnt    <= 4'd0;
      pit_cnt    <= 8'd0;
      cur_div    <= DIV_NORM;
      core_rst_n <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
      case (state)
        S_WAIT: begin
          stab_cnt <= 16'd0;
          if (locked_s) state <= S_STAB;
        end
        S_STAB: begin
          if (!locked_s) begin
            state    <= S_WAIT;
            stab_cnt <= 16'd0;
          end else if (stab_cnt == STAB_LAST) begin
            // Entering RUN: both dividers restart at 0 and the CPU divisor
            // is captured from the current turbo selection.
            state      <= S_RUN;
            stab_cnt   <= 16'd0;
            core_rst_n <= 1'b1;
            cpu_cnt    <= 4'd0;
            pit_cnt    <= 8'd0;
            cur_div    <= sel_div;
          end else begin
            stab_cnt <= stab_cnt + 16'd1;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state      <= S_WAIT;
            core_rst_n <= 1'b0;
            lock_lost  <= 1'b1;
            cpu_cnt    <= 4'd0;
            pit_cnt    <= 8'd0;
          end else begin
            // Divisor only changes at a period boundary so a turbo toggle
            // never produces a truncated or stretched CPU period.
            if (cpu_wrap) begin
              cpu_cnt <= 4'd0;
              cur_div <= sel_div;
            end else begin
              cpu_cnt <= cpu_cnt + 4'd1;
            end
            pit_cnt <= pit_wrap ? 8'd0 : pit_cnt + 8'd1;
          end
        end
        default: begin
          state      <= S_WAIT;
          stab_cnt   <= 16'd0;
          cpu_cnt    <= 4'd0;
          pit_cnt    <= 8'd0;
          core_rst_n <= 1'b0;
        end
      endcase
    end
  end

  // Enables are decoded purely from registers and gated by RUN, so they
  // drop on the same edge as core_rst_n.
  assign cpu_ce  = in_run & cpu_wrap;
  assign cpu_clk = in_run & clk_high;
  assign pit_ce  = in_run & pit_wrap;

endmodule
`default_nettype wire

// File: tb/tb_pcxt_clk_en_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcxt_clk_en_gen
// Purpose  : Self-checking bench for pcxt_clk_en_gen (LOCK_WAIT=16). A
//            reference model tracks the lock streak, RUN cycle index and CPU
//            period countdown and predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcxt_clk_en_gen;

  localparam int LW  = 16;
  localparam int DN  = 3;
  localparam int DT  = 2;
  localparam int PIT = 12;

  logic clk = 1'b0;
  logic rst_n, pll_locked, turbo;
  logic core_rst_n, cpu_ce, cpu_clk, pit_ce, lock_lost;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_s1, m_s2, m_streak, m_run, m_lost, m_k, m_len, m_rem;

  pcxt_clk_en_gen #(
    .LOCK_WAIT    (LW),
    .CPU_DIV_NORM (DN),
    .CPU_DIV_TURBO(DT),
    .PIT_DIV      (PIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .turbo     (turbo),
    .core_rst_n(core_rst_n),
    .cpu_ce    (cpu_ce),
    .cpu_clk   (cpu_clk),
    .pit_ce    (pit_ce),
    .lock_lost (lock_lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int div_of(input logic t);
    return t ? DT : DN;
  endfunction

  function automatic int high_of(input int len);
    if (len == 1) return 1;
    return len / 2;
  endfunction

  // One clock edge of the model, using the inputs present at the edge.
  // RUN holds whenever the synchronized lock has been seen high on at least
  // LW+1 consecutive edges (one edge to leave WAIT, LW edges of counting).
  task automatic model_step();
    int ls, prev_run;
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_streak = 0; m_run = 0; m_lost = 0;
      m_k = 0; m_len = DN; m_rem = DN;
    end else begin
      ls       = m_s2;
      m_s2     = m_s1;
      m_s1     = int'(pll_locked);
      prev_run = m_run;
      m_streak = ls ? m_streak + 1 : 0;
      m_run    = (m_streak >= LW + 1) ? 1 : 0;
      if (prev_run && !m_run) m_lost = 1;
      if (m_run && !prev_run) begin
        m_k = 0; m_len = div_of(turbo); m_rem = m_len;
      end else if (m_run) begin
        m_k++;
        if (m_rem == 1) begin
          m_len = div_of(turbo); m_rem = m_len;
        end else begin
          m_rem--;
        end
      end
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("core_rst_n", int'(core_rst_n), m_run);
      check("cpu_ce",  int'(cpu_ce),  (m_run && m_rem == 1) ? 1 : 0);
      check("cpu_clk", int'(cpu_clk), (m_run && (m_len - m_rem) < high_of(m_len)) ? 1 : 0);
      check("pit_ce",  int'(pit_ce),  (m_run && (m_k % PIT) == PIT - 1) ? 1 : 0);
      check("lock_lost", int'(lock_lost), m_lost);
    end
  endtask

  initial begin
    m_s1 = 0; m_s2 = 0; m_streak = 0; m_run = 0; m_lost = 0;
    m_k = 0; m_len = DN; m_rem = DN;
    rst_n = 1'b0; pll_locked = 1'b1; turbo = 1'b0;
    step(3);                       // reset with lock high
    rst_n = 1'b1; pll_locked = 1'b0;
    step(5);
    pll_locked = 1'b1; step(14);   // into STAB
    pll_locked = 1'b0; step(1);    // one-cycle glitch
    pll_locked = 1'b1; step(50);   // full re-acquisition and RUN
    turbo = 1'b1; step(25);
    turbo = 1'b0; step(1);
    turbo = 1'b1; step(1);
    turbo = 1'b0; step(25);
    pll_locked = 1'b0; step(1);    // lock loss in RUN
    pll_locked = 1'b1; step(40);   // re-lock, lock_lost stays
    pll_locked = 1'b0; step(1);
    pll_locked = 1'b1; step(40);   // second loss
    rst_n = 1'b0; step(1);         // reset mid-RUN
    rst_n = 1'b1; step(40);
    for (int c = 0; c < 6000; c++) begin
      if (pll_locked) pll_locked = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      else            pll_locked = ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 14) == 0) turbo = ~turbo;
      rst_n = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
      step(1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
